thor2023_regfile_mp: RTL and testbench

Parametrised multi-port general register file for the Thor2023 core, successor to the fixed 4-read/1-write, 128-bit file. It adds configurable width, depth, read/write port count and register sets, plus a hardware clear sequencer that zeroes every register after reset or on request. Write-to-read bypass forwarding is built in. It sits between the decode/operand-fetch stage and the writeback stage.

---
 rtl/thor2023_regfile_mp.sv | 162 ++++++++++++++++
 tb/tb_thor2023_regfile_mp.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thor2023_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : thor2023_regfile_mp
// Purpose  : Multi-port, multi-set register file with write bypass and a
//            hardware clear sequencer.
// Revision : 1.0
// ============================================================================
module thor2023_regfile_mp #(
  parameter int WID   = 128,
  parameter int NREGS = 64,
  parameter int NSETS = 2,
  parameter int NRD   = 4,
  parameter int NWR   = 2,
  parameter int RDLAT = 0,
  parameter int SCREG = 53,
  localparam int AW   = $clog2(NREGS),
  localparam int SW   = (NSETS > 1) ? $clog2(NSETS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  output logic               busy,
  input  logic [SW-1:0]      wset,
  input  logic [SW-1:0]      rset,
  input  logic [NWR-1:0]     wr,
  input  logic [NWR*AW-1:0]  wa,
  input  logic [NWR*WID-1:0] wd,
  input  logic [NRD*AW-1:0]  ra,
  output logic [NRD*WID-1:0] rd,
  output logic [WID-1:0]     sc
);

  localparam int NLOC = NSETS * NREGS;
  localparam int CW   = (NLOC > 1) ? $clog2(NLOC) : 1;
  localparam logic [CW-1:0] C_LAST    = CW'(NLOC - 1);
  localparam logic [AW-1:0] C_SC_ADDR = AW'(SCREG);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WID-1:0]          sc_q, sc_d;
  logic [WID-1:0]          mem_q [NLOC];
  logic [WID-1:0]          mem_d [NLOC];
  logic [NRD-1:0][WID-1:0] rd_d;

  // With a single set the set bit is dropped by the truncating cast.
  function automatic logic [CW-1:0] loc(input logic [SW-1:0] s, input logic [AW-1:0] a);
    return CW'({s, a});
  endfunction

  assign busy = (state_q == ST_CLEAR);
  assign sc   = sc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Later ports overwrite earlier ones, giving the higher index priority.
  always_comb begin
    mem_d = mem_q;
    if (busy) begin
      mem_d[cnt_q] = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr[j] && (wa[j*AW +: AW] != '0)) begin
          mem_d[loc(wset, wa[j*AW +: AW])] = wd[j*WID +: WID];
        end
      end
    end
  end

  always_comb begin
    sc_d = sc_q;
    if (busy) begin
      sc_d = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr[j] && (wset == '0) && (wa[j*AW +: AW] == C_SC_ADDR)) begin
          sc_d = wd[j*WID +: WID];
        end
      end
    end
  end

  // A nonzero read address can only match a nonzero write address, so the
  // r0 bypass exclusion falls out of the ra check.
  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!busy && (ra[k*AW +: AW] != '0)) begin
        rd_d[k] = mem_q[loc(rset, ra[k*AW +: AW])];
        for (int j = 0; j < NWR; j++) begin
          if (wr[j] && (wset == rset) && (wa[j*AW +: AW] == ra[k*AW +: AW])) begin
            rd_d[k] = wd[j*WID +: WID];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
    end
  end

  // Storage has no reset; the sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  generate
    if (RDLAT == 0) begin : g_rd_comb
      assign rd = rd_d;
    end else begin : g_rd_reg
      logic [NRD-1:0][WID-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end
      assign rd = rd_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_thor2023_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_thor2023_regfile_mp
// Purpose  : Scoreboard bench for thor2023_regfile_mp, default parameters.
// Revision : 1.0
// ============================================================================
module tb_thor2023_regfile_mp;

  localparam int WID   = 128;
  localparam int NREGS = 64;
  localparam int NSETS = 2;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int AW    = 6;
  localparam int SW    = 1;
  localparam int SCREG = 53;

  logic               clk = 1'b0;
  logic               rst;
  logic               clr;
  logic               busy;
  logic [SW-1:0]      wset;
  logic [SW-1:0]      rset;
  logic [NWR-1:0]     wr;
  logic [NWR*AW-1:0]  wa;
  logic [NWR*WID-1:0] wd;
  logic [NRD*AW-1:0]  ra;
  logic [NRD*WID-1:0] rd;
  logic [WID-1:0]     sc;

  thor2023_regfile_mp #(
    .WID(WID), .NREGS(NREGS), .NSETS(NSETS), .NRD(NRD), .NWR(NWR),
    .RDLAT(0), .SCREG(SCREG)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .wset(wset), .rset(rset), .wr(wr), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .sc(sc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             port;
    logic [WID-1:0] val;
  } exp_t;

  exp_t           exp_q[$];
  logic [WID-1:0] model [NSETS][NREGS];
  logic [WID-1:0] sc_model;
  bit             clearing;
  int             n_tests = 0;
  int             n_fail  = 0;

  task automatic idle_inputs();
    wr = '0; wa = '0; wd = '0; ra = '0; clr = 1'b0; wset = '0; rset = '0;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [WID-1:0] d);
    wr[j] = 1'b1;
    wa[j*AW +: AW] = a;
    wd[j*WID +: WID] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  task automatic push_exp(input int k, input logic [WID-1:0] v);
    exp_t e;
    e.port = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic model_zero();
    for (int s = 0; s < NSETS; s++)
      for (int a = 0; a < NREGS; a++)
        model[s][a] = '0;
    sc_model = '0;
  endtask

  function automatic logic [WID-1:0] model_read(input int k);
    logic [AW-1:0]  a;
    logic [WID-1:0] v;
    a = ra[k*AW +: AW];
    if (clearing || a == '0) return '0;
    v = model[rset][a];
    for (int j = 0; j < NWR; j++)
      if (wr[j] && wset == rset && wa[j*AW +: AW] == a) v = wd[j*WID +: WID];
    return v;
  endfunction

  task automatic push_reads();
    for (int k = 0; k < NRD; k++) push_exp(k, model_read(k));
  endtask

  // Commit the cycle's writes to the model, then advance to the next negedge.
  task automatic tick();
    logic [AW-1:0] a;
    if (!clearing) begin
      for (int j = 0; j < NWR; j++) begin
        a = wa[j*AW +: AW];
        if (wr[j] && a != '0) begin
          model[wset][a] = wd[j*WID +: WID];
          if (wset == '0 && a == AW'(SCREG)) sc_model = wd[j*WID +: WID];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return AW'(SCREG);
      2:       return AW'(7);
      default: return AW'($urandom_range(0, NREGS - 1));
    endcase
  endfunction

  task automatic test_reset();
    int cycles;
    idle_inputs();
    rst = 1'b1;
    clearing = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 1", busy);
    end
    n_tests++;
    if (sc !== '0) begin
      n_fail++; $display("FAIL reset_sc: got %h expected 0", sc);
    end
    rst = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      cycles++;
      @(posedge clk);
      @(negedge clk);
    end
    n_tests++;
    if (cycles != 128) begin
      n_fail++; $display("FAIL reset_clear_len: got %0d cycles expected 128", cycles);
    end
    clearing = 1'b0;
    model_zero();
  endtask

  task automatic test_readback(input string tag);
    exp_t e;
    for (int s = 0; s < NSETS; s++) begin
      for (int a = 0; a < NREGS; a += NRD) begin
        idle_inputs();
        rset = SW'(s);
        for (int k = 0; k < NRD; k++) set_rd(k, AW'(a + k));
        push_reads();
        #1;
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          if (rd[e.port*WID +: WID] !== e.val) begin
            n_fail++;
            $display("FAIL readback_%s set%0d r%0d: got %h expected %h",
                     tag, s, a + e.port, rd[e.port*WID +: WID], e.val);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_write_read_bypass();
    exp_t e;
    for (int step = 0; step < 3; step++) begin
      idle_inputs();
      case (step)
        0: begin
          wset = 1'b1; rset = 1'b1;
          set_wr(0, 5, 128'h1234);
          set_rd(0, 5); set_rd(1, 5); set_rd(2, 6);
          push_exp(0, 128'h1234); push_exp(1, 128'h1234); push_exp(2, '0);
        end
        1: begin
          rset = 1'b1; set_rd(0, 5); push_exp(0, 128'h1234);
        end
        default: begin
          rset = 1'b0; set_rd(0, 5); push_exp(0, '0);
        end
      endcase
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (rd[e.port*WID +: WID] !== e.val) begin
          n_fail++;
          $display("FAIL wr_rd_bypass step%0d rd[%0d]: got %h expected %h",
                   step, e.port, rd[e.port*WID +: WID], e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_port_conflict();
    exp_t e;
    for (int step = 0; step < 2; step++) begin
      idle_inputs();
      if (step == 0) begin
        set_wr(0, 7, 128'hAA);
        set_wr(1, 7, 128'hBB);
      end
      set_rd(0, 7);
      set_rd(3, 7);
      push_exp(0, 128'hBB);
      push_exp(3, 128'hBB);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (rd[e.port*WID +: WID] !== e.val) begin
          n_fail++;
          $display("FAIL port_conflict step%0d rd[%0d]: got %h expected %h",
                   step, e.port, rd[e.port*WID +: WID], e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_r0_sc();
    exp_t e;
    for (int step = 0; step < 5; step++) begin
      idle_inputs();
      case (step)
        0: begin
          set_wr(0, 0, 128'hFF); set_wr(1, 0, 128'hEE);
          set_rd(0, 0); push_exp(0, '0);
        end
        1: begin
          set_rd(0, 0); push_exp(0, '0);
          set_wr(0, AW'(SCREG), 128'h77);
        end
        2: begin
          wset = 1'b1; rset = 1'b1;
          set_wr(1, AW'(SCREG), 128'h99);
          set_rd(1, AW'(SCREG)); push_exp(1, 128'h99);
        end
        3: begin
          rset = 1'b1; set_rd(2, AW'(SCREG)); push_exp(2, 128'h99);
        end
        default: begin
          set_rd(2, AW'(SCREG)); push_exp(2, 128'h77);
        end
      endcase
      #1;
      if (step >= 2) begin
        n_tests++;
        if (sc !== 128'h77) begin
          n_fail++; $display("FAIL sc_shadow step%0d: got %h expected %h", step, sc, 128'h77);
        end
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (rd[e.port*WID +: WID] !== e.val) begin
          n_fail++;
          $display("FAIL r0_sc step%0d rd[%0d]: got %h expected %h",
                   step, e.port, rd[e.port*WID +: WID], e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int cyc = 0; cyc < 300; cyc++) begin
      idle_inputs();
      wset = SW'($urandom_range(0, 1));
      rset = SW'($urandom_range(0, 1));
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 2) != 0) set_wr(j, rand_addr(), {$urandom, $urandom, $urandom, $urandom});
      for (int k = 0; k < NRD; k++) set_rd(k, rand_addr());
      push_reads();
      #1;
      n_tests++;
      if (sc !== sc_model) begin
        n_fail++; $display("FAIL b2b_sc cyc%0d: got %h expected %h", cyc, sc, sc_model);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (rd[e.port*WID +: WID] !== e.val) begin
          n_fail++;
          $display("FAIL b2b cyc%0d rd[%0d]: got %h expected %h",
                   cyc, e.port, rd[e.port*WID +: WID], e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_clr();
    exp_t e;
    int   cycles;
    for (int s = 0; s < NSETS; s++) begin
      for (int a = 1; a < NREGS; a += 2) begin
        idle_inputs();
        wset = SW'(s);
        set_wr(0, AW'(a), {28'hC0FFEE0, 4'(s), 90'd0, 6'(a)});
        if (a + 1 < NREGS) set_wr(1, AW'(a + 1), {28'hC0FFEE0, 4'(s), 90'd0, 6'(a + 1)});
        tick();
      end
    end
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    clearing = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      wset = SW'($urandom_range(0, 1));
      rset = SW'($urandom_range(0, 1));
      set_wr(0, AW'($urandom_range(1, NREGS - 1)), {4{$urandom}});
      set_wr(1, AW'(SCREG), 128'h5A5A);
      for (int k = 0; k < NRD; k++) begin
        set_rd(k, AW'($urandom_range(1, NREGS - 1)));
        push_exp(k, '0);
      end
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (rd[e.port*WID +: WID] !== e.val) begin
          n_fail++;
          $display("FAIL clr_busy_rd cyc%0d rd[%0d]: got %h expected %h",
                   cycles, e.port, rd[e.port*WID +: WID], e.val);
        end
      end
      cycles++;
      tick();
    end
    idle_inputs();
    n_tests++;
    if (cycles != 128) begin
      n_fail++; $display("FAIL clr_len: got %0d cycles expected 128", cycles);
    end
    clearing = 1'b0;
    model_zero();
    n_tests++;
    if (sc !== '0) begin
      n_fail++; $display("FAIL clr_sc: got %h expected 0", sc);
    end
  endtask

  task automatic test_mid_clear();
    int cycles;
    for (int mode = 0; mode < 2; mode++) begin
      idle_inputs();
      set_wr(0, 10, 128'h55);
      tick();
      idle_inputs();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      clearing = 1'b1;
      repeat (40) tick();
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL mid_busy_at40 mode%0d: got %b expected 1", mode, busy);
      end
      if (mode == 0) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
      end else begin
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL mid_rst_busy: got %b expected 1", busy);
        end
        rst = 1'b0;
      end
      cycles = 0;
      while (busy === 1'b1 && cycles < 400) begin
        cycles++;
        tick();
      end
      n_tests++;
      if (cycles != 128) begin
        n_fail++; $display("FAIL mid_clear_len mode%0d: got %0d cycles expected 128", mode, cycles);
      end
      clearing = 1'b0;
      model_zero();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    clearing = 1'b1;
    model_zero();
    test_reset();
    test_readback("reset");
    test_write_read_bypass();
    test_port_conflict();
    test_r0_sc();
    test_back_to_back();
    test_readback("random");
    test_clr();
    test_readback("clr");
    test_mid_clear();
    test_readback("mid");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
